bcd2dist: RTL and testbench

- Sequential decimal-to-binary converter, the reverse of the distance-to-BCD display path.
- Accepts decimal digits one per strobe, most significant digit first, from keypad/UART entry logic.
- Accumulates the digits into a binary distance value; on commit, range-checks it and presents a 7-bit distance.
- Output feeds the threshold/reference-distance registers and can be echoed back through the display path.

---
 rtl/bcd2dist.sv | 89 ++++++++
 tb/tb_bcd2dist.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd2dist.sv
// bcd2dist: accumulates MSD-first BCD digits into a binary value and commits a range-checked distance.
module bcd2dist #(
    parameter int MAX_DIGITS = 3,
    parameter int DIST_MAX   = 127,
    parameter int DW         = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          digit_valid,
    input  logic [3:0]    digit,
    input  logic          commit,
    input  logic          clear,
    output logic [DW-1:0] dist_out,
    output logic          dist_valid,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [1:0]    digit_count,
    output logic [9:0]    acc_out
);
    typedef enum logic [1:0] {IDLE, ENTRY, DONE, ERROR} state_t;
    localparam logic [1:0] MAXD = 2'(MAX_DIGITS);
    localparam logic [9:0] DMAX = 10'(DIST_MAX);
    state_t state, state_nx;
    logic [9:0] acc, acc_nx, acc_x10;
    logic [1:0] cnt_nx, code_nx;
    logic [DW-1:0] dist_nx;
    logic valid_nx;
    assign acc_x10 = (acc << 3) + (acc << 1) + {6'b0, digit};
    assign acc_out = acc;
    assign err = state == ERROR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc <= '0;
            digit_count <= '0;
            err_code <= '0;
            dist_out <= '0;
            dist_valid <= 1'b0;
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            digit_count <= cnt_nx;
            err_code <= code_nx;
            dist_out <= dist_nx;
            dist_valid <= valid_nx;
        end
    end
    // clear beats commit beats digit_valid; ERROR only leaves via clear
    always_comb begin
        state_nx = state;
        acc_nx = acc;
        cnt_nx = digit_count;
        code_nx = err_code;
        dist_nx = dist_out;
        valid_nx = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            acc_nx = '0;
            cnt_nx = '0;
            code_nx = '0;
        end else if (state != ERROR) begin
            if (commit) begin
                if (state == ENTRY && acc <= DMAX) begin
                    state_nx = DONE;
                    dist_nx = acc[DW-1:0];
                    valid_nx = 1'b1;
                end else begin
                    state_nx = ERROR;
                    code_nx = 2'd3;
                end
            end else if (digit_valid) begin
                if (digit > 4'd9) begin
                    state_nx = ERROR;
                    code_nx = 2'd1;
                end else if (state != ENTRY) begin
                    state_nx = ENTRY;
                    acc_nx = {6'b0, digit};
                    cnt_nx = 2'd1;
                end else if (digit_count >= MAXD) begin
                    state_nx = ERROR;
                    code_nx = 2'd2;
                end else begin
                    acc_nx = acc_x10;
                    cnt_nx = digit_count + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd2dist.sv
// tb_bcd2dist: scoreboard bench; expected committed distances are queued at commit and popped on dist_valid.
module tb_bcd2dist;
    logic clk = 0, rst_n = 0, digit_valid = 0, commit = 0, clear = 0;
    logic [3:0] digit = 0;
    logic [6:0] dist_out;
    logic dist_valid, err;
    logic [1:0] err_code, digit_count;
    logic [9:0] acc_out;
    int n_chk = 0, n_fail = 0;
    int sb[$];

    bcd2dist dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .commit(commit), .clear(clear), .dist_out(dist_out), .dist_valid(dist_valid),
        .err(err), .err_code(err_code), .digit_count(digit_count), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dist_valid) begin
            if (sb.size() == 0) check("spurious_valid", int'(dist_valid), 0);
            else check("sb_dist_out", int'(dist_out), sb.pop_front());
        end
    end

    task automatic dig(input logic [3:0] d);
        digit_valid = 1; digit = d;
        @(posedge clk); #1;
        digit_valid = 0;
    endtask

    task automatic cmt();
        commit = 1;
        @(posedge clk); #1;
        commit = 0;
    endtask

    task automatic clr();
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_dist_out", int'(dist_out), 0);
        check("rst_err", int'(err), 0);
        check("rst_acc", int'(acc_out), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        dig(1); check("acc_1", int'(acc_out), 1);
        dig(2); check("acc_12", int'(acc_out), 12);
        dig(7); check("acc_127", int'(acc_out), 127);
        check("cnt_3", int'(digit_count), 3);
        sb.push_back(127);
        cmt();
        check("valid_127", int'(dist_valid), 1);
        check("dist_127", int'(dist_out), 127);
        check("err_ok", int'(err), 0);
        idle(1);
        check("valid_drop", int'(dist_valid), 0);

        dig(1); dig(2); dig(8);
        check("acc_128", int'(acc_out), 128);
        cmt();
        check("range_err", int'(err), 1);
        check("range_code", int'(err_code), 3);
        check("range_hold", int'(dist_out), 127);
        idle(2);

        clr();
        dig(4); dig(2); dig(5); dig(3);
        check("many_err", int'(err), 1);
        check("many_code", int'(err_code), 2);
        cmt();
        check("err_commit_ign", int'(err_code), 2);
        clr();
        check("clr_err", int'(err), 0);
        check("clr_cnt", int'(digit_count), 0);
        check("clr_code", int'(err_code), 0);

        dig(4'hA);
        check("bad_err", int'(err), 1);
        check("bad_code", int'(err_code), 1);
        clr();
        cmt();
        check("empty_code", int'(err_code), 3);
        clr();

        digit_valid = 1; digit = 5; commit = 1; clear = 1;
        @(posedge clk); #1;
        digit_valid = 0; commit = 0; clear = 0;
        check("prio_acc", int'(acc_out), 0);
        check("prio_cnt", int'(digit_count), 0);
        check("prio_err", int'(err), 0);
        check("prio_valid", int'(dist_valid), 0);
        dig(0); dig(0);
        check("lz_cnt", int'(digit_count), 2);
        dig(9);
        check("lz_acc", int'(acc_out), 9);
        sb.push_back(9);
        cmt();
        check("dist_9", int'(dist_out), 9);
        idle(1);

        dig(1); dig(2);
        #3 rst_n = 0;
        #1;
        check("arst_acc", int'(acc_out), 0);
        check("arst_cnt", int'(digit_count), 0);
        check("arst_dist", int'(dist_out), 0);
        check("arst_err", int'(err) | int'(err_code) | int'(dist_valid), 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        dig(6); dig(4);
        check("acc_64", int'(acc_out), 64);
        sb.push_back(64);
        cmt();
        check("dist_64", int'(dist_out), 64);
        idle(3);
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
